// File: rtl/pack_posit_seq.sv
// Sequential posit encoder: turns decoded posit fields (sign, regime k,
// exponent, 1.frac mantissa, zero/NaR flags) into an N-bit posit word with
// round-to-nearest-even. The regime run is shifted in one bit per cycle,
// and both sides use valid/ready handshakes.
module pack_posit_seq #(
  parameter int N         = 16,
  parameter int ES        = 1,
  parameter int K_SIZE    = $clog2(N) + 1,
  parameter int MANT_SIZE = N - 2 - ES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign,
  input  logic [K_SIZE-1:0]    k,
  input  logic [ES-1:0]        exp,
  input  logic [MANT_SIZE-1:0] mant,
  input  logic                 is_zero,
  input  logic                 is_nar,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         bits
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t              state, state_next;
  logic [N-1:0]        ext;
  logic                sticky;
  logic [K_SIZE-1:0]   cnt;
  logic                r_q;
  logic                sign_q;

  logic                accept;
  int                  k_int;
  int                  k_clamp;
  int                  run_len;
  logic                clamped;
  logic                r_load;
  logic [ES-1:0]       exp_load;
  logic [MANT_SIZE-2:0] frac_load;
  logic [N-1:0]        ext_load;
  logic [K_SIZE-1:0]   cnt_load;

  logic [N-2:0]        body;
  logic                guard;
  logic                round_up;
  logic [N-1:0]        mag;
  logic [N-1:0]        bits_round;

  // The hidden bit of mant is implied by the encoding and never read.
  logic unused_hidden;
  assign unused_hidden = mant[MANT_SIZE-1];

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  // NOTE: every combinational output is assigned a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (is_nar || is_zero) ? DONE : SHIFT;
      SHIFT: if (cnt == K_SIZE'(1)) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load values: clamp k into the representable regime range, then derive
  // the regime polarity, run length and the initial shift register contents.
  always_comb begin
    k_int     = int'($signed(k));
    k_clamp   = k_int;
    clamped   = 1'b0;
    if (k_int > N - 2) begin
      k_clamp = N - 2;
      clamped = 1'b1;
    end else if (k_int < -(N - 2)) begin
      k_clamp = -(N - 2);
      clamped = 1'b1;
    end
    r_load    = (k_clamp >= 0);
    run_len   = r_load ? k_clamp + 1 : -k_clamp;
    // A clamped value saturates to maxpos/minpos, so its tail is dropped.
    exp_load  = clamped ? '0 : exp;
    frac_load = clamped ? '0 : mant[MANT_SIZE-2:0];
    ext_load  = {~r_load, exp_load, frac_load, 2'b00};
    cnt_load  = K_SIZE'(run_len);
  end

  // Round-to-nearest-even on the shifted word and apply the sign.
  always_comb begin
    body       = ext[N-1:1];
    guard      = ext[0];
    round_up   = guard && (sticky || body[0]);
    mag        = {1'b0, body} + N'(round_up);
    bits_round = sign_q ? (~mag + N'(1)) : mag;
  end

  // Datapath: load on accept, shift the regime in, round, hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext       <= '0;
      sticky    <= 1'b0;
      cnt       <= '0;
      r_q       <= 1'b0;
      sign_q    <= 1'b0;
      bits      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= sign;
            if (is_nar) begin
              bits      <= {1'b1, {(N-1){1'b0}}};
              out_valid <= 1'b1;
            end else if (is_zero) begin
              bits      <= '0;
              out_valid <= 1'b1;
            end else begin
              ext    <= ext_load;
              sticky <= 1'b0;
              cnt    <= cnt_load;
              r_q    <= r_load;
            end
          end
        end
        SHIFT: begin
          ext    <= {r_q, ext[N-1:1]};
          sticky <= sticky | ext[0];
          cnt    <= cnt - K_SIZE'(1);
        end
        ROUND: begin
          bits      <= bits_round;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_posit_seq.sv
// Self-checking bench for pack_posit_seq (N=16, ES=1): directed corner cases
// plus randomized encodes against a bit-string reference model.
module tb_pack_posit_seq;

  localparam int N = 16;
  localparam int ES = 1;
  localparam int K_SIZE = 5;
  localparam int MANT_SIZE = 13;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 t_sign;
  logic [K_SIZE-1:0]    t_k;
  logic [ES-1:0]        t_exp;
  logic [MANT_SIZE-1:0] t_mant;
  logic                 t_zero;
  logic                 t_nar;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         bits;

  int total = 0;
  int bad   = 0;

  pack_posit_seq #(.N(N), .ES(ES), .K_SIZE(K_SIZE), .MANT_SIZE(MANT_SIZE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign(t_sign), .k(t_k), .exp(t_exp), .mant(t_mant),
    .is_zero(t_zero), .is_nar(t_nar),
    .out_valid(out_valid), .out_ready(out_ready), .bits(bits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: write the posit as a bit string (regime run, terminator,
  // exponent, fraction), keep N-1 bits and round the rest to nearest even.
  function automatic logic [15:0] model(input bit s, input int kv, input int e,
                                        input int f, input bit z, input bit nar,
                                        output int lat);
    bit   seq[$];
    int   kc, run, ee, ff;
    bit   r, guard, sticky;
    logic [15:0] val;
    if (nar) begin lat = 1; return 16'h8000; end
    if (z)   begin lat = 1; return 16'h0000; end
    kc = kv; ee = e; ff = f;
    if (kv > N - 2)    begin kc = N - 2;    ee = 0; ff = 0; end
    if (kv < -(N - 2)) begin kc = -(N - 2); ee = 0; ff = 0; end
    r   = (kc >= 0);
    run = r ? kc + 1 : -kc;
    for (int i = 0; i < run; i++) seq.push_back(r);
    seq.push_back(!r);
    seq.push_back(ee[0]);
    for (int i = 11; i >= 0; i--) seq.push_back(ff[i]);
    while (seq.size() < N) seq.push_back(1'b0);
    val = '0;
    for (int i = 0; i < N - 1; i++) val = {val[14:0], seq[i]};
    guard  = seq[N-1];
    sticky = 1'b0;
    for (int i = N; i < seq.size(); i++) sticky = sticky | seq[i];
    if (guard && (sticky || val[0])) val = val + 16'd1;
    if (s) val = -val;
    lat = run + 2;
    return val;
  endfunction

  // One full transaction: accept, wait for the result, optional backpressure,
  // output handshake. Inputs are scrambled right after the accept edge.
  task automatic run_txn(input string tag, input bit s, input int kv, input int e,
                         input int f, input bit z, input bit nar, input int hold);
    logic [15:0] want;
    logic [15:0] held;
    int lat, cycles, wait_n;
    want = model(s, kv, e, f, z, nar, lat);
    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      @(posedge clk); #1; wait_n++;
    end
    if (!in_ready) check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    t_sign = s; t_k = K_SIZE'(kv); t_exp = ES'(e);
    t_mant = {1'($urandom), 12'(f)}; t_zero = z; t_nar = nar;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t_sign = 1'($urandom); t_k = K_SIZE'($urandom); t_exp = ES'($urandom);
    t_mant = MANT_SIZE'($urandom); t_zero = 1'($urandom); t_nar = 1'($urandom);
    cycles = 1;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1; cycles++;
    end
    check({tag, "_lat"}, 32'(cycles), 32'(lat));
    check({tag, "_bits"}, 32'(bits), 32'(want));
    held = bits;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_bits"}, 32'(bits), 32'(held));
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_bits"}, 32'(bits), 32'(want));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    t_sign = 1'b0; t_k = '0; t_exp = '0; t_mant = '0; t_zero = 1'b0; t_nar = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bits", 32'(bits), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Unit values.
    run_txn("one",     0, 0, 0, 12'h000, 0, 0, 0);
    run_txn("neg_one", 1, 0, 0, 12'h000, 0, 0, 0);
    // Extremes and clamping (k=15 / -16 are the widest 5-bit k values).
    run_txn("maxpos",     0, 14, 0, 12'h000, 0, 0, 0);
    run_txn("clamp_hi",   0, 15, 1, 12'hABC, 0, 0, 0);
    run_txn("minpos",     0, -14, 0, 12'h000, 0, 0, 0);
    run_txn("clamp_lo",   0, -16, 1, 12'h123, 0, 0, 0);
    run_txn("clamp_lo_n", 1, -16, 0, 12'hFFF, 0, 0, 0);
    // Rounding near maxpos.
    run_txn("rne_tie", 0, 13, 1, 12'h000, 0, 0, 0);
    run_txn("rne_up",  0, 13, 1, 12'h001, 0, 0, 0);
    run_txn("rne_dn",  0, 13, 0, 12'hFFF, 0, 0, 0);
    // Specials.
    run_txn("nar",      0, 3, 1, 12'h555, 0, 1, 0);
    run_txn("zero",     1, 3, 1, 12'h555, 1, 0, 0);
    run_txn("nar_zero", 0, 3, 1, 12'h555, 1, 1, 0);
    // Backpressure.
    run_txn("bp", 1, 2, 1, 12'h9A5, 0, 0, 5);

    // Reset in the middle of a k=10 encode.
    t_sign = 0; t_k = K_SIZE'(10); t_exp = '0; t_mant = 13'h1000; t_zero = 0; t_nar = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bits", 32'(bits), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_rel", 32'(in_ready), 32'd1);
    run_txn("after_rst", 0, 0, 0, 12'h000, 0, 0, 0);

    // Randomized encodes.
    for (int i = 0; i < 200; i++) begin
      int kv, sel;
      kv  = int'($urandom_range(31)) - 16;
      sel = int'($urandom_range(19));
      run_txn("rand", 1'($urandom), kv, int'($urandom_range(1)),
              int'($urandom_range(4095)), sel == 0, sel == 1,
              int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
